// File: rtl/kbd_pkg.sv
// kbd_pkg: types and constants shared by the keyboard event queue and its FIFO.
//
// Contents:
//   - KBD_ROWS, KBD_COLS, KBD_CODE_W: matrix geometry and key-code width.
//   - EVT_W: width of one queued event.
//   - kbd_evt_t: packed event layout {[ts], press, code}.
//   - kbd_state_e: change-detect FSM states.
//
// Optional feature: define KBD_EVT_TIMESTAMP_EN to add a 16-bit timestamp to
// every event (EVT_W = 24). Without the macro, EVT_W = 8.
package kbd_pkg;

  localparam int KBD_ROWS   = 9;
  localparam int KBD_COLS   = 10;
  localparam int KBD_CODE_W = 7;

`ifdef KBD_EVT_TIMESTAMP_EN
  localparam int KBD_TS_W = 16;
  localparam int EVT_W    = KBD_TS_W + 1 + KBD_CODE_W;

  typedef struct packed {
    logic [KBD_TS_W-1:0]   ts;
    logic                  press;
    logic [KBD_CODE_W-1:0] code;
  } kbd_evt_t;
`else
  localparam int EVT_W = 1 + KBD_CODE_W;

  typedef struct packed {
    logic                  press;
    logic [KBD_CODE_W-1:0] code;
  } kbd_evt_t;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } kbd_state_e;

endpackage

// File: rtl/kbd_evt_fifo.sv
// kbd_evt_fifo: synchronous first-word-fall-through FIFO.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   push_i            write request; ignored (and reported on drop_o) when full
//                     unless a pop happens in the same cycle
//   push_data_i       word to write
//   pop_i             read request; only acts when valid_o is high
//   data_o            head word while valid_o is high, zero when empty
//   valid_o           FIFO non-empty (registered)
//   count_o           occupancy, 0..DEPTH
//   drop_o            push rejected this cycle because the FIFO was full
//
// No configuration macros.
module kbd_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             valid_q;

  logic full;
  logic do_pop;
  logic do_push;

  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & valid_q;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & full & ~do_pop;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
    end
  end

  // Storage is pure data and needs no reset; data_o is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  assign data_o  = valid_q ? mem_q[rd_q] : '0;
  assign valid_o = valid_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/kbd_event_queue.sv
// kbd_event_queue: turns per-column debounced row snapshots into key
// press/release events and queues them for the CPU.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   scan_valid/ready/col/row  snapshot handshake from the matrix scanner
//   evt_valid/data/ready      FWFT event queue head and pop
//   evt_count       queue occupancy
//   overflow        sticky: an event was dropped on a full queue
//   overflow_clr    clears overflow (a simultaneous drop wins)
//   irq             level interrupt, equal to evt_valid
//
// Optional feature: KBD_EVT_TIMESTAMP_EN adds a free-running 16-bit cycle
// counter whose value at push time is stored in evt_data[23:8].
module kbd_event_queue
  import kbd_pkg::*;
#(
  parameter int ROWS  = KBD_ROWS,
  parameter int COLS  = KBD_COLS,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scan_valid,
  output logic                   scan_ready,
  input  logic [3:0]             scan_col,
  input  logic [ROWS-1:0]        scan_row,
  output logic                   evt_valid,
  output logic [EVT_W-1:0]       evt_data,
  input  logic                   evt_ready,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic                   irq
);

  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;

  kbd_state_e    state_q;
  logic          scan_ready_q;
  logic [ROWS-1:0] key_state_q [COLS];
  logic [ROWS-1:0] diff_q;
  logic [ROWS-1:0] diff_d;
  logic [ROWS-1:0] row_q;
  logic [3:0]      col_q;
  logic            overflow_q;

  logic            accept;
  logic            col_ok;
  logic [ROWS-1:0] snap_diff;
  logic [RIW-1:0]  low_r;
  logic            push;
  logic            drop;
  kbd_evt_t        evt;

`ifdef KBD_EVT_TIMESTAMP_EN
  logic [KBD_TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + KBD_TS_W'(1);
  end
`endif

  assign accept    = scan_valid & scan_ready_q;
  assign col_ok    = (32'(scan_col) < COLS);
  assign snap_diff = col_ok ? (scan_row ^ key_state_q[scan_col]) : '0;

  // Lowest set bit of the pending diff; scanning downwards leaves the
  // smallest index as the final assignment.
  always_comb begin
    low_r = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (diff_q[r]) low_r = RIW'(r);
    end
  end

  // Clearing the lowest set bit: x & (x - 1).
  assign diff_d = diff_q & (diff_q - ROWS'(1));
  assign push   = (state_q == ST_EMIT);

  always_comb begin
    evt       = '0;
    evt.press = row_q[low_r];
    evt.code  = KBD_CODE_W'(32'(low_r) * COLS + 32'(col_q));
`ifdef KBD_EVT_TIMESTAMP_EN
    evt.ts    = ts_q;
`endif
  end

  // Change-detect FSM and key state memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      scan_ready_q <= 1'b1;
      for (int c = 0; c < COLS; c++) key_state_q[c] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && col_ok) begin
            key_state_q[scan_col] <= scan_row;
            if (snap_diff != '0) begin
              state_q      <= ST_EMIT;
              scan_ready_q <= 1'b0;
            end
          end
        end
        ST_EMIT: begin
          if (diff_d == '0) begin
            state_q      <= ST_IDLE;
            scan_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          scan_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Snapshot latch for the EMIT walk; pure data, no reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && accept && col_ok) begin
      diff_q <= snap_diff;
      row_q  <= scan_row;
      col_q  <= scan_col;
    end else if (state_q == ST_EMIT) begin
      diff_q <= diff_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               overflow_q <= 1'b0;
    else if (drop)         overflow_q <= 1'b1;
    else if (overflow_clr) overflow_q <= 1'b0;
  end

  kbd_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (evt),
    .pop_i       (evt_ready),
    .data_o      (evt_data),
    .valid_o     (evt_valid),
    .count_o     (evt_count),
    .drop_o      (drop)
  );

  assign scan_ready = scan_ready_q;
  assign overflow   = overflow_q;
  assign irq        = evt_valid;

endmodule
